// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: sequences fetch/decode/exec/mem/writeback with
// ready handshakes on both memories, a memory-wait watchdog and an illegal-opcode trap.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             Z,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic [1:0]       pcsel,
  output logic [1:0]       wasel,
  output logic [1:0]       wdsel,
  output logic [1:0]       asel,
  output logic             bsel,
  output logic             sext,
  output logic [4:0]       alufn,
  output logic             werf,
  output logic             wr,
  output logic             dmem_re,
  output logic             pc_we,
  output logic             ir_we,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic [1:0]       trap
);

  // Handshake: imem_ready / dmem_ready are sampled only in FETCH / MEM while
  // enabled; the transfer happens in the cycle ready is high, and the request
  // (ir_we wait, dmem_re / wr) is held unchanged until then.

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b10001;
  localparam logic [4:0] ALU_SLT  = 5'b10011;
  localparam logic [4:0] ALU_SLTU = 5'b10111;
  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b01000;
  localparam logic [4:0] ALU_NOR  = 5'b01100;
  localparam logic [4:0] ALU_SLL  = 5'b00010;
  localparam logic [4:0] ALU_SRL  = 5'b01010;
  localparam logic [4:0] ALU_SRA  = 5'b01110;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t             cur_state, state_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W:0]    wait_inc;
  logic               waiting, timeout_hit, active, commit;
  logic [1:0]         trap_q, trap_set;
  logic               legal, is_beq, is_bne, is_j, is_jal, is_jr, is_lw, is_sw;

  // Datapath selects depend only on op/func, so they stay stable while the IR holds.
  always_comb begin
    legal  = 1'b0;
    is_beq = 1'b0;
    is_bne = 1'b0;
    is_j   = 1'b0;
    is_jal = 1'b0;
    is_jr  = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    wasel  = 2'b00;
    wdsel  = 2'b01;
    asel   = 2'b00;
    bsel   = 1'b0;
    sext   = 1'b1;
    alufn  = ALU_ADD;
    case (op)
      6'h00: begin
        case (func)
          6'h00: begin legal = 1'b1; asel = 2'b01; alufn = ALU_SLL; end
          6'h02: begin legal = 1'b1; asel = 2'b01; alufn = ALU_SRL; end
          6'h03: begin legal = 1'b1; asel = 2'b01; alufn = ALU_SRA; end
          6'h04: begin legal = 1'b1; alufn = ALU_SLL; end
          6'h08: begin legal = 1'b1; is_jr = 1'b1; end
          6'h20, 6'h21: begin legal = 1'b1; alufn = ALU_ADD; end
          6'h22: begin legal = 1'b1; alufn = ALU_SUB; end
          6'h24: begin legal = 1'b1; alufn = ALU_AND; end
          6'h25: begin legal = 1'b1; alufn = ALU_OR; end
          6'h26: begin legal = 1'b1; alufn = ALU_XOR; end
          6'h27: begin legal = 1'b1; alufn = ALU_NOR; end
          6'h2a: begin legal = 1'b1; alufn = ALU_SLT; end
          6'h2b: begin legal = 1'b1; alufn = ALU_SLTU; end
          default: ;
        endcase
      end
      6'h02: begin legal = 1'b1; is_j = 1'b1; end
      6'h03: begin legal = 1'b1; is_jal = 1'b1; wasel = 2'b10; wdsel = 2'b00; end
      6'h04: begin legal = 1'b1; is_beq = 1'b1; alufn = ALU_SUB; end
      6'h05: begin legal = 1'b1; is_bne = 1'b1; alufn = ALU_SUB; end
      6'h08, 6'h09: begin legal = 1'b1; wasel = 2'b01; bsel = 1'b1; alufn = ALU_ADD; end
      6'h0a: begin legal = 1'b1; wasel = 2'b01; bsel = 1'b1; alufn = ALU_SLT; end
      6'h0b: begin legal = 1'b1; wasel = 2'b01; bsel = 1'b1; alufn = ALU_SLTU; end
      6'h0c: begin legal = 1'b1; wasel = 2'b01; bsel = 1'b1; sext = 1'b0; alufn = ALU_AND; end
      6'h0d: begin legal = 1'b1; wasel = 2'b01; bsel = 1'b1; sext = 1'b0; alufn = ALU_OR; end
      6'h0e: begin legal = 1'b1; wasel = 2'b01; bsel = 1'b1; sext = 1'b0; alufn = ALU_XOR; end
      6'h0f: begin legal = 1'b1; wasel = 2'b01; asel = 2'b10; bsel = 1'b1; alufn = ALU_SLL; end
      6'h23: begin legal = 1'b1; is_lw = 1'b1; wasel = 2'b01; wdsel = 2'b10; bsel = 1'b1; end
      6'h2b: begin legal = 1'b1; is_sw = 1'b1; bsel = 1'b1; end
      default: ;
    endcase
  end

  assign active   = enable & ~reset;
  assign waiting  = ((cur_state == S_FETCH) & ~imem_ready) |
                    ((cur_state == S_MEM) & ~dmem_ready);
  assign wait_inc = {1'b0, wait_cnt} + (WAIT_W + 1)'(1);
  // The wait that would bring the counter to TIMEOUT is the last one allowed.
  assign timeout_hit = (TIMEOUT != 0) && (wait_inc == (WAIT_W + 1)'(TIMEOUT));

  always_comb begin
    state_next = cur_state;
    werf       = 1'b0;
    wr         = 1'b0;
    dmem_re    = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    commit     = 1'b0;
    pcsel      = 2'b00;
    trap_set   = 2'b00;
    case (cur_state)
      S_FETCH: begin
        if (imem_ready) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          trap_set   = 2'b10;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_next = S_EXEC;
        end else begin
          state_next = S_TRAP;
          trap_set   = 2'b01;
        end
      end
      S_EXEC: begin
        if (is_beq | is_bne | is_j | is_jal | is_jr) begin
          commit     = 1'b1;
          werf       = is_jal;
          state_next = S_FETCH;
          if (is_j | is_jal)                      pcsel = 2'b10;
          else if (is_jr)                         pcsel = 2'b11;
          else if ((is_beq & Z) | (is_bne & ~Z))  pcsel = 2'b01;
        end else if (is_lw | is_sw) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_re = is_lw;
        wr      = is_sw;
        if (dmem_ready) begin
          commit     = is_sw;
          state_next = is_sw ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          trap_set   = 2'b10;
        end
      end
      S_WB: begin
        werf       = 1'b1;
        commit     = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: ;
      default: state_next = S_FETCH;
    endcase
    pc_we = commit;
    if (!active) begin
      state_next = cur_state;
      werf       = 1'b0;
      wr         = 1'b0;
      dmem_re    = 1'b0;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      commit     = 1'b0;
      trap_set   = 2'b00;
      if (reset) pcsel = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
      instret   <= '0;
      trap_q    <= 2'b00;
    end else if (enable) begin
      cur_state <= state_next;
      if (state_next != cur_state)
        wait_cnt <= '0;
      else if (waiting && (TIMEOUT != 0))
        wait_cnt <= wait_inc[WAIT_W-1:0];
      if (commit)
        instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
      if (trap_set != 2'b00)
        trap_q <= trap_set;
    end
  end

  assign instr_done = commit;
  assign state      = cur_state;
  assign trap       = trap_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: state sequences, strobes, branch
// resolution, watchdog/illegal traps and enable freezing, with TIMEOUT=4.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset, enable, z, imem_ready, dmem_ready;
  logic [5:0]  op, func;
  logic [1:0]  pcsel, wasel, wdsel, asel, trap;
  logic        bsel, sext, werf, wr, dmem_re, pc_we, ir_we, instr_done;
  logic [4:0]  alufn;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [5:0]  strobes;

  int total = 0;
  int bad   = 0;

  multicycle_controller #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .op(op), .func(func), .Z(z),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .pcsel(pcsel),
    .wasel(wasel), .wdsel(wdsel), .asel(asel), .bsel(bsel), .sext(sext),
    .alufn(alufn), .werf(werf), .wr(wr), .dmem_re(dmem_re), .pc_we(pc_we),
    .ir_we(ir_we), .state(state), .instr_done(instr_done), .instret(instret),
    .trap(trap)
  );

  // {werf, wr, dmem_re, pc_we, ir_we, instr_done}
  assign strobes = {werf, wr, dmem_re, pc_we, ir_we, instr_done};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    op = 6'h00; func = 6'h20; z = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1; enable = 1'b1; reset = 1'b1;
    next_cycle();
    next_cycle();
    settle();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++; if (strobes !== 6'b0) begin bad++; $display("FAIL reset_strobes: got %b want 000000", strobes); end
    total++; if (instret !== 32'd0) begin bad++; $display("FAIL reset_instret: got %0d want 0", instret); end
    total++; if (trap !== 2'b00) begin bad++; $display("FAIL reset_trap: got %b want 00", trap); end
    total++; if (pcsel !== 2'b00) begin bad++; $display("FAIL reset_pcsel: got %b want 00", pcsel); end
    reset = 1'b0;
    settle();
    total++; if (strobes !== 6'b000010) begin bad++; $display("FAIL reset_release_irwe: got %b want 000010", strobes); end
  endtask

  task automatic test_add();
    logic [2:0] exp_st [4];
    logic [5:0] exp_sb [4];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
    exp_sb = '{6'b000010, 6'b000000, 6'b000000, 6'b100101};
    op = 6'h00; func = 6'h20; imem_ready = 1'b1; dmem_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      settle();
      total++; if (state !== exp_st[c]) begin bad++; $display("FAIL add_state c%0d: got %0d want %0d", c + 1, state, exp_st[c]); end
      total++; if (strobes !== exp_sb[c]) begin bad++; $display("FAIL add_strobes c%0d: got %b want %b", c + 1, strobes, exp_sb[c]); end
      if (c == 3) begin
        total++; if (wasel !== 2'b00) begin bad++; $display("FAIL add_wasel: got %b want 00", wasel); end
        total++; if (wdsel !== 2'b01) begin bad++; $display("FAIL add_wdsel: got %b want 01", wdsel); end
        total++; if ((alufn & 5'b10011) !== 5'b00001) begin bad++; $display("FAIL add_alufn: got %b want 0xx01", alufn); end
      end
      next_cycle();
    end
    settle();
    total++; if (instret !== 32'd1) begin bad++; $display("FAIL add_instret: got %0d want 1", instret); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL add_back_to_fetch: got %0d want 0", state); end
    // decode-only checks on the combinational selects
    op = 6'h0c; settle();
    total++; if ({sext, bsel, wasel} !== 4'b0101) begin bad++; $display("FAIL andi_sel: got %b want 0101", {sext, bsel, wasel}); end
    total++; if ((alufn & 5'b01111) !== 5'b00000) begin bad++; $display("FAIL andi_alufn: got %b want x0000", alufn); end
    op = 6'h00; func = 6'h00; settle();
    total++; if (asel !== 2'b01) begin bad++; $display("FAIL sll_asel: got %b want 01", asel); end
    op = 6'h0f; settle();
    total++; if ({asel, bsel, sext} !== 4'b1011) begin bad++; $display("FAIL lui_sel: got %b want 1011", {asel, bsel, sext}); end
  endtask

  task automatic test_lw();
    logic [2:0] exp_st [8];
    logic [5:0] exp_sb [8];
    int done_cnt = 0;
    int re_cnt = 0;
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    exp_sb = '{6'b000010, 6'b000000, 6'b000000, 6'b001000, 6'b001000,
               6'b001000, 6'b001000, 6'b100101};
    op = 6'h23; func = 6'h00; imem_ready = 1'b1; dmem_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c == 6) dmem_ready = 1'b1;
      settle();
      done_cnt += int'(instr_done);
      re_cnt   += int'(dmem_re);
      total++; if (state !== exp_st[c]) begin bad++; $display("FAIL lw_state c%0d: got %0d want %0d", c + 1, state, exp_st[c]); end
      total++; if (strobes !== exp_sb[c]) begin bad++; $display("FAIL lw_strobes c%0d: got %b want %b", c + 1, strobes, exp_sb[c]); end
      if (c == 7) begin
        total++; if ({wasel, wdsel} !== 4'b0110) begin bad++; $display("FAIL lw_wb_sel: got %b want 0110", {wasel, wdsel}); end
      end
      next_cycle();
    end
    settle();
    total++; if (done_cnt != 1) begin bad++; $display("FAIL lw_done_count: got %0d want 1", done_cnt); end
    total++; if (re_cnt != 4) begin bad++; $display("FAIL lw_re_count: got %0d want 4", re_cnt); end
    total++; if (instret !== 32'd1) begin bad++; $display("FAIL lw_instret: got %0d want 1", instret); end
    total++; if (trap !== 2'b00) begin bad++; $display("FAIL lw_ready_wins: got trap %b want 00", trap); end
  endtask

  task automatic test_branch();
    logic [5:0] br_op [4];
    logic       br_z  [4];
    logic [1:0] br_pc [4];
    br_op = '{6'h04, 6'h05, 6'h05, 6'h04};
    br_z  = '{1'b1, 1'b1, 1'b0, 1'b0};
    br_pc = '{2'b01, 2'b00, 2'b01, 2'b00};
    func = 6'h00; imem_ready = 1'b1; dmem_ready = 1'b1;
    op = br_op[0]; z = br_z[0];
    do_reset();
    settle();
    total++; if (instret !== 32'd0) begin bad++; $display("FAIL branch_reset_instret: got %0d want 0", instret); end
    for (int i = 0; i < 4; i++) begin
      op = br_op[i]; z = br_z[i];
      next_cycle();
      next_cycle();
      settle();
      total++; if (state !== 3'd2) begin bad++; $display("FAIL branch%0d_state: got %0d want 2", i, state); end
      total++; if (pcsel !== br_pc[i]) begin bad++; $display("FAIL branch%0d_pcsel: got %b want %b", i, pcsel, br_pc[i]); end
      total++; if (strobes !== 6'b000101) begin bad++; $display("FAIL branch%0d_strobes: got %b want 000101", i, strobes); end
      next_cycle();
    end
    settle();
    total++; if (instret !== 32'd4) begin bad++; $display("FAIL branch_instret: got %0d want 4", instret); end
  endtask

  task automatic test_jump();
    logic [5:0] j_op [3];
    logic [5:0] j_fn [3];
    logic [1:0] j_pc [3];
    logic [5:0] j_sb [3];
    j_op = '{6'h03, 6'h02, 6'h00};
    j_fn = '{6'h00, 6'h00, 6'h08};
    j_pc = '{2'b10, 2'b10, 2'b11};
    j_sb = '{6'b100101, 6'b000101, 6'b000101};
    imem_ready = 1'b1; dmem_ready = 1'b1; z = 1'b0;
    op = j_op[0]; func = j_fn[0];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      op = j_op[i]; func = j_fn[i];
      next_cycle();
      next_cycle();
      settle();
      total++; if (state !== 3'd2) begin bad++; $display("FAIL jump%0d_state: got %0d want 2", i, state); end
      total++; if (pcsel !== j_pc[i]) begin bad++; $display("FAIL jump%0d_pcsel: got %b want %b", i, pcsel, j_pc[i]); end
      total++; if (strobes !== j_sb[i]) begin bad++; $display("FAIL jump%0d_strobes: got %b want %b", i, strobes, j_sb[i]); end
      if (i == 0) begin
        total++; if ({wasel, wdsel} !== 4'b1000) begin bad++; $display("FAIL jal_sel: got %b want 1000", {wasel, wdsel}); end
      end
      next_cycle();
    end
    settle();
    total++; if (instret !== 32'd3) begin bad++; $display("FAIL jump_instret: got %0d want 3", instret); end
  endtask

  task automatic test_traps();
    op = 6'h00; func = 6'h20; imem_ready = 1'b0; dmem_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      settle();
      total++; if ({state, strobes} !== 9'b0) begin bad++; $display("FAIL tmo_wait c%0d: got state %0d strobes %b want 0 000000", c, state, strobes); end
      next_cycle();
    end
    settle();
    total++; if (state !== 3'd7) begin bad++; $display("FAIL tmo_state: got %0d want 7", state); end
    total++; if (trap !== 2'b10) begin bad++; $display("FAIL tmo_trap: got %b want 10", trap); end
    imem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      settle();
      total++; if ({state, strobes} !== {3'd7, 6'b0}) begin bad++; $display("FAIL tmo_absorb c%0d: got state %0d strobes %b want 7 000000", c, state, strobes); end
    end
    op = 6'h3f;
    do_reset();
    settle();
    total++; if (trap !== 2'b00) begin bad++; $display("FAIL ill_reset_trap: got %b want 00", trap); end
    next_cycle();
    settle();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL ill_decode: got %0d want 1", state); end
    next_cycle();
    settle();
    total++; if (state !== 3'd7) begin bad++; $display("FAIL ill_state: got %0d want 7", state); end
    total++; if (trap !== 2'b01) begin bad++; $display("FAIL ill_trap: got %b want 01", trap); end
    next_cycle();
    settle();
    total++; if (strobes !== 6'b0) begin bad++; $display("FAIL ill_strobes: got %b want 000000", strobes); end
  endtask

  task automatic test_enable();
    int done_cnt = 0;
    op = 6'h2b; func = 6'h00; imem_ready = 1'b1; dmem_ready = 1'b0;
    do_reset();
    next_cycle();
    next_cycle();
    next_cycle();
    settle();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL en_mem_state: got %0d want 3", state); end
    total++; if (strobes !== 6'b010000) begin bad++; $display("FAIL en_mem_wr: got %b want 010000", strobes); end
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      enable = 1'b0;
      dmem_ready = (c >= 4);
      settle();
      done_cnt += int'(instr_done);
      total++; if ({state, strobes} !== {3'd3, 6'b0}) begin bad++; $display("FAIL en_frozen c%0d: got state %0d strobes %b want 3 000000", c, state, strobes); end
    end
    next_cycle();
    enable = 1'b1;
    settle();
    done_cnt += int'(instr_done);
    total++; if ({state, strobes} !== {3'd3, 6'b010101}) begin bad++; $display("FAIL en_resume: got state %0d strobes %b want 3 010101", state, strobes); end
    next_cycle();
    settle();
    done_cnt += int'(instr_done);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL en_after_state: got %0d want 0", state); end
    total++; if (instret !== 32'd1) begin bad++; $display("FAIL en_instret: got %0d want 1", instret); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL en_done_count: got %0d want 1", done_cnt); end
    total++; if (trap !== 2'b00) begin bad++; $display("FAIL en_no_trap: got %b want 00", trap); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; op = 6'h00; func = 6'h00; z = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_jump();
    test_traps();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state control unit for the multicycle MIPS core, replacing the single-cycle decoder. It sequences each instruction through fetch/decode/execute/memory/writeback states and tolerates variable-latency instruction and data memories via ready handshakes. It adds a memory-wait watchdog, an illegal-opcode trap and a retired-instruction counter. It drives the same datapath select encodings as the single-cycle core, plus PC, IR and memory strobes.

## Interface
- `TIMEOUT`, 16: maximum wait cycles in FETCH or MEM before trapping; 0 disables the watchdog.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: 0 freezes the FSM, counters and all strobes.
- `op` in 6: opcode from the IR. `func` in 6: function field from the IR.
- `Z` in 1: ALU zero flag, valid in EXEC.
- `imem_ready` in 1: instruction word valid this cycle. `dmem_ready` in 1: data access completes this cycle.
- `pcsel` out 2: 00 pc+4, 01 branch target, 10 jump target, 11 rs (JR).
- `wasel` out 2: 00 rd, 01 rt, 10 r31.
- `wdsel` out 2: 00 pc+4, 01 ALU, 10 memory.
- `asel` out 2: 00 rs, 01 shamt, 10 constant 16 (LUI).
- `bsel` out 1: 1 selects the immediate. `sext` out 1: 1 sign-extends the immediate.
- `alufn` out 5: ALU function. Values: add 0xx01, sub 1xx01, slt 1x011, sltu 1x111, and x0000, or x0100, xor x1000, nor x1100, sll x0010, srl x1010, sra x1110.
- `werf` out 1: register-file write strobe. `wr` out 1: data-memory write strobe. `dmem_re` out 1: data-memory read request.
- `pc_we` out 1: PC load strobe. `ir_we` out 1: IR load strobe.
- `state` out 3: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 7.
- `instr_done` out 1: single-cycle pulse when an instruction commits.
- `instret` out CNT_W: count of retired instructions.
- `trap` out 2: 00 none, 01 illegal instruction, 10 timeout. Sticky until reset.

## Operation
- Supported instructions:
  - I/J-type: LW, SW, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, BEQ, BNE, J, JAL.
  - R-type: ADD, ADDU, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SLLV, SRL, SRA, JR.
  - Any other op/func combination is illegal.
- Selects `wasel`, `wdsel`, `asel`, `bsel`, `sext`, `alufn` are combinational from op/func and held stable in every state after FETCH.
  - ANDI, ORI and XORI zero-extend. All other immediates sign-extend.
  - Shifts by shamt use asel=01.
- FETCH: `ir_we`=1 only in the cycle `imem_ready`=1, then go to DECODE. Otherwise stay and count wait cycles.
- DECODE: one cycle. An illegal instruction goes to TRAP; all others go to EXEC.
- EXEC:
  - BEQ, BNE, J, JR: commit here. pcsel=01 only if (BEQ&Z)|(BNE&~Z), else 00 for branches.
  - JAL: commit here with `werf`=1, wasel=10, wdsel=00.
  - LW, SW: go to MEM.
  - All others: go to WB.
- MEM:
  - `dmem_re`=1 for LW, `wr`=1 for SW, held until `dmem_ready`.
  - SW commits on `dmem_ready`. LW goes to WB on `dmem_ready`.
- WB: `werf`=1, commit, return to FETCH.
- Commit cycle: `pc_we`=1 with pcsel valid, `instr_done`=1, `instret`+1 (wraps at 2^CNT_W). Exactly one commit per instruction.
- Watchdog: a wait counter clears on entering FETCH or MEM.
  - If TIMEOUT≠0 and it reaches TIMEOUT with ready still low, go to TRAP with trap=10.
  - A ready arriving in the same cycle the counter reaches TIMEOUT wins; no trap.
- TRAP: absorbing. All strobes stay 0 until reset. An illegal instruction sets trap=01.
- `enable`=0: state, wait counter and `instret` hold. `werf`, `wr`, `pc_we`, `ir_we`, `dmem_re` and `instr_done` are forced to 0. Ready inputs are ignored while disabled.

## Timing
- Reset: state=FETCH, `instret`=0, `trap`=00, wait counter 0, all strobes 0, pcsel=00.
- Strobes are Moore/Mealy combinations of the registered state and the ready inputs. No strobe asserts in the cycle `reset` is high.
- Reset mid-instruction abandons the instruction with no commit and no write.
- Latency with zero-wait memory (ready already high):
  - Branch/J/JR/JAL: 3 cycles.
  - R-type/ALU immediate: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1.
- `instret` updates on the clock edge following the commit cycle.

## Test plan
- Reset, then ADD (op 0, func 100000) with both readies high. Expect states 0,1,2,4. `werf`=1 in cycle 4 with wasel=00, wdsel=01, alufn=0xx01. `instret`=1.
- LW with `dmem_ready` delayed 3 cycles. Expect `dmem_re` high for 4 cycles, then WB with wdsel=10, wasel=01. Total 8 cycles; `instr_done` pulses once.
- BEQ with Z=1, then BNE with Z=1. Expect pcsel=01 with `pc_we` in EXEC for BEQ, pcsel=00 for BNE. No `werf`.
- JAL: `werf`=1, wasel=10, wdsel=00, pcsel=10 in EXEC. Three-cycle instruction.
- TIMEOUT=4, `imem_ready` held low. Expect TRAP at cycle 5 with trap=10 and no strobes afterward. Opcode 111111 expects trap=01.
- Drop `enable` during MEM of a SW. Expect `wr`=0 and state frozen. Re-enable; the store completes with a single commit.
